ff_lane_skid: RTL and testbench

FF_LANE_SKID -- requirements
Module: ff_lane_skid

---
 rtl/ff_lane_skid.sv | 104 ++++++++++
 tb/tb_ff_lane_skid.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ff_lane_skid.sv
// Two-entry lane-qualified skid buffer: MAIN presents the head beat and SKID absorbs one extra beat.
// in_ready depends only on stored state and reset, so there is no combinational path from downstream.
module ff_lane_skid #(
  parameter int unsigned NLANES       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ZERO_IDLE    = 1,
  parameter int unsigned MASK_INVALID = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NLANES*DATA_W-1:0] in_data,
  input  logic [NLANES-1:0]        in_lane_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NLANES*DATA_W-1:0] out_data,
  output logic [NLANES-1:0]        out_lane_valid,
  output logic [1:0]               occupancy
);

  localparam int unsigned BUS_W = NLANES * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q;
  logic [BUS_W-1:0]   main_data_q;
  logic [NLANES-1:0]  main_lv_q;
  logic [BUS_W-1:0]   skid_data_q;
  logic [NLANES-1:0]  skid_lv_q;

  logic [BUS_W-1:0]   data_c;
  logic [NLANES-1:0]  lv_c;

  // State and storage; the state value doubles as the occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_lv_q   <= '0;
      skid_data_q <= '0;
      skid_lv_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_data_q <= in_data;
            main_lv_q   <= in_lane_valid;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            main_data_q <= in_data;
            main_lv_q   <= in_lane_valid;
          end else if (in_valid) begin
            skid_data_q <= in_data;
            skid_lv_q   <= in_lane_valid;
            state_q     <= FULL;
          end else if (out_ready) begin
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_data_q <= skid_data_q;
            main_lv_q   <= skid_lv_q;
            state_q     <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign in_ready  = !reset && (state_q != FULL);
  assign out_valid = !reset && (state_q != EMPTY);
  assign occupancy = reset ? 2'd0 : state_q;

  // Output view of MAIN: invalid lanes masked, idle and reset read as zero.
  always_comb begin
    data_c = main_data_q;
    lv_c   = main_lv_q;
    if (MASK_INVALID != 0) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        if (!main_lv_q[i]) begin
          data_c[i*DATA_W +: DATA_W] = '0;
        end
      end
    end
    if (reset || ((ZERO_IDLE != 0) && (state_q == EMPTY))) begin
      data_c = '0;
      lv_c   = '0;
    end
  end

  assign out_data       = data_c;
  assign out_lane_valid = lv_c;

endmodule

// File: tb/tb_ff_lane_skid.sv
// Bench for ff_lane_skid: directed vector table, streaming run and randomized run against a queue model.
module tb_ff_lane_skid;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_lane_valid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_lane_valid;
  logic [1:0]  occupancy;

  logic [31:0] w1_data;
  logic [0:0]  w1_lv;
  logic        w1_ir, w1_ov;
  logic [31:0] w1_od;
  logic [0:0]  w1_olv;
  logic [1:0]  w1_occ;

  logic [63:0] w8_data;
  logic [7:0]  w8_lv;
  logic        w8_ir, w8_ov;
  logic [63:0] w8_od;
  logic [7:0]  w8_olv;
  logic [1:0]  w8_occ;

  int vec_cnt = 0;
  int err_cnt = 0;

  assign w1_data = in_data;
  assign w1_lv   = in_lane_valid[0];
  assign w8_data = {in_data, in_data};
  assign w8_lv   = {in_lane_valid, in_lane_valid};

  ff_lane_skid u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lane_valid(in_lane_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lane_valid(out_lane_valid),
    .occupancy(occupancy)
  );

  ff_lane_skid #(.NLANES(1), .DATA_W(32)) u_w1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w1_ir),
    .in_data(w1_data), .in_lane_valid(w1_lv), .out_valid(w1_ov),
    .out_ready(out_ready), .out_data(w1_od), .out_lane_valid(w1_olv),
    .occupancy(w1_occ)
  );

  ff_lane_skid #(.NLANES(8), .DATA_W(8)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w8_ir),
    .in_data(w8_data), .in_lane_valid(w8_lv), .out_valid(w8_ov),
    .out_ready(out_ready), .out_data(w8_od), .out_lane_valid(w8_olv),
    .occupancy(w8_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  lv;
  } beat_t;

  beat_t mq[$];

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] d;
    logic [3:0]  lv;
    logic        ordy;
    logic        eov;
    logic        eir;
    logic [1:0]  eocc;
    logic [31:0] ed;
    logic [3:0]  elv;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] masked(input beat_t b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (b.lv[i]) r[i*8 +: 8] = b.d[i*8 +: 8];
    end
    return r;
  endfunction

  // Advance one clock: the model uses the pre-edge inputs, outputs are sampled 1 ns after the edge.
  task automatic step();
    bit do_push, do_pop;
    beat_t nb;
    do_push = !reset && in_valid && (mq.size() < 2);
    do_pop  = !reset && out_ready && (mq.size() > 0);
    nb = '{d: in_data, lv: in_lane_valid};
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(nb);
    end
    #1;
  endtask

  task automatic check_model(input string name);
    logic        eov, eir;
    logic [1:0]  eocc;
    logic [31:0] ed;
    logic [3:0]  elv;
    eov  = !reset && (mq.size() > 0);
    eir  = !reset && (mq.size() < 2);
    eocc = reset ? 2'd0 : 2'(mq.size());
    ed   = eov ? masked(mq[0]) : 32'h0;
    elv  = eov ? mq[0].lv : 4'h0;
    check(name, 72'({out_valid, in_ready, occupancy, out_data, out_lane_valid}),
          72'({eov, eir, eocc, ed, elv}));
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] d,
                       input logic [3:0] lv, input logic ordy);
    reset         = r;
    in_valid      = iv;
    in_data       = d;
    in_lane_valid = lv;
    out_ready     = ordy;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);

    //          rst   iv    data          lv     ordy  eov   eir   occ    exp data      exp lv
    tbl[0]  = '{1'b1, 1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00000000, 4'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'hDDCCBBAA, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 32'hDDCCBBAA, 4'hF};
    tbl[3]  = '{1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, 32'hDDCCBBAA, 4'h5, 1'b0, 1'b1, 1'b1, 2'd1, 32'h00CC00AA, 4'h5};
    tbl[5]  = '{1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 32'h11111111, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11111111, 4'hF};
    tbl[7]  = '{1'b0, 1'b1, 32'h22222222, 4'hF, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11111111, 4'hF};
    tbl[8]  = '{1'b0, 1'b1, 32'h33333333, 4'hF, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11111111, 4'hF};
    tbl[9]  = '{1'b0, 1'b1, 32'h33333333, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 32'h22222222, 4'hF};
    tbl[10] = '{1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 4'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 4'h0};
    tbl[12] = '{1'b0, 1'b1, 32'h44444444, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 32'h44444444, 4'hF};
    tbl[13] = '{1'b0, 1'b1, 32'h55555555, 4'hF, 1'b0, 1'b1, 1'b0, 2'd2, 32'h44444444, 4'hF};
    tbl[14] = '{1'b1, 1'b1, 32'h66666666, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 32'h00000000, 4'h0};
    tbl[15] = '{1'b0, 1'b1, 32'h77777777, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 32'h77777777, 4'hF};
    tbl[16] = '{1'b0, 1'b0, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 4'h0};

    repeat (2) @(posedge clk);
    #1;

    // Directed table: main instance against constants, the two width variants alongside.
    for (int r = 0; r < 17; r++) begin
      drive(tbl[r].rst, tbl[r].iv, tbl[r].d, tbl[r].lv, tbl[r].ordy);
      step();
      check($sformatf("tbl%0d", r),
            72'({out_valid, in_ready, occupancy, out_data, out_lane_valid}),
            72'({tbl[r].eov, tbl[r].eir, tbl[r].eocc, tbl[r].ed, tbl[r].elv}));
      check($sformatf("tbl%0d_model", r),
            72'({out_valid, in_ready, occupancy, out_data, out_lane_valid}),
            72'({tbl[r].eov, tbl[r].eir, tbl[r].eocc, (mq.size() > 0 && !reset) ? masked(mq[0]) : 32'h0,
                 (mq.size() > 0 && !reset) ? mq[0].lv : 4'h0}));
      check($sformatf("tbl%0d_w1_ctl", r), 72'({w1_ov, w1_ir, w1_occ}),
            72'({tbl[r].eov, tbl[r].eir, tbl[r].eocc}));
      check($sformatf("tbl%0d_w8_ctl", r), 72'({w8_ov, w8_ir, w8_occ}),
            72'({tbl[r].eov, tbl[r].eir, tbl[r].eocc}));
      if (tbl[r].elv == 4'hF || tbl[r].elv == 4'h0) begin
        check($sformatf("tbl%0d_w1_data", r), 72'(w1_od), 72'(tbl[r].ed));
        check($sformatf("tbl%0d_w8_data", r), 72'(w8_od), 72'({tbl[r].ed, tbl[r].ed}));
      end
    end

    // Streaming: one beat per cycle with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(i);
      drive(1'b0, 1'b1, {b, b, b, b}, 4'hF, 1'b1);
      step();
      check($sformatf("stream%0d", i), 72'({in_ready, out_valid, out_data}),
            72'({1'b1, 1'b1, b, b, b, b}));
      check_model($sformatf("stream%0d_model", i));
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
    step();
    check_model("stream_drain");

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), $urandom,
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
